// File: rtl/pc_sequencer.sv
// Instruction-fetch sequencer: owns the PC, resolves JMP/BLE/CALL/RET/NOP and keeps a private return-address stack.
// Optional timed NOP (DELAY state plus 24-bit counter) is enabled by defining PC_SEQ_TIMED_NOP_EN.
module pc_sequencer #(
    parameter logic [3:0]  OP_NOP    = 4'd0,
    parameter logic [3:0]  OP_JMP    = 4'd1,
    parameter logic [3:0]  OP_BLE    = 4'd2,
    parameter logic [3:0]  OP_CALL   = 4'd3,
    parameter logic [3:0]  OP_RET    = 4'd4,
    parameter int          RAS_DEPTH = 8,
    parameter logic [15:0] RESET_PC  = 16'd0
) (
    input  logic                         Clock,
    input  logic                         Reset,
    input  logic [27:0]                  iInstruction,
    input  logic                         iBranchTaken,
    input  logic                         iStall,
    output logic [15:0]                  oAddress,
    output logic                         oInstrValid,
    output logic [$clog2(RAS_DEPTH):0]   oStackDepth,
    output logic                         oStackError
);

    localparam int AW = $clog2(RAS_DEPTH);
    localparam int DW = AW + 1;
    localparam logic [DW-1:0] DEPTH_FULL = DW'(RAS_DEPTH);
    localparam logic [DW-1:0] DEPTH_ONE  = {{AW{1'b0}}, 1'b1};

`ifdef PC_SEQ_TIMED_NOP_EN
    typedef enum logic [1:0] {ST_SETTLE = 2'd0, ST_RUN = 2'd1, ST_DELAY = 2'd2} state_t;
    logic [23:0] cnt_r;
    logic [23:0] cnt_next_s;
`else
    typedef enum logic [0:0] {ST_SETTLE = 1'b0, ST_RUN = 1'b1} state_t;
    logic        unused_count_s;
    assign unused_count_s = ^iInstruction[15:0];
`endif

    state_t          state_r;
    state_t          state_next_s;
    logic [15:0]     pc_r;
    logic [15:0]     pc_next_s;
    logic [15:0]     pc_plus1_s;
    logic [DW-1:0]   depth_r;
    logic [DW-1:0]   depth_dec_s;
    logic            err_r;
    logic            push_s;
    logic            pop_s;
    logic            err_set_s;
    logic            instr_valid_s;
    logic [15:0]     stack_r [0:RAS_DEPTH-1];
    logic [3:0]      opcode_s;
    logic [15:0]     target_s;

    assign opcode_s    = iInstruction[27:24];
    assign target_s    = {8'd0, iInstruction[23:16]};
    assign pc_plus1_s  = pc_r + 16'd1;
    assign depth_dec_s = depth_r - DEPTH_ONE;

    // State register: PC, FSM state and (optionally) the NOP delay counter.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            pc_r    <= RESET_PC;
            state_r <= ST_SETTLE;
`ifdef PC_SEQ_TIMED_NOP_EN
            cnt_r   <= 24'd0;
`endif
        end else begin
            pc_r    <= pc_next_s;
            state_r <= state_next_s;
`ifdef PC_SEQ_TIMED_NOP_EN
            cnt_r   <= cnt_next_s;
`endif
        end
    end

    // Next-state logic: stall freezes everything; the settle state only lets the ROM output become valid.
    always_comb begin
        state_next_s = state_r;
        pc_next_s    = pc_r;
        push_s       = 1'b0;
        pop_s        = 1'b0;
        err_set_s    = 1'b0;
`ifdef PC_SEQ_TIMED_NOP_EN
        cnt_next_s   = cnt_r;
`endif
        if (iStall) begin
            state_next_s = state_r;
        end else begin
            case (state_r)
                ST_SETTLE: state_next_s = ST_RUN;
                ST_RUN: begin
                    case (opcode_s)
                        OP_JMP: pc_next_s = target_s;
                        OP_BLE: begin
                            if (iBranchTaken) begin
                                pc_next_s = target_s;
                            end else begin
                                pc_next_s = pc_plus1_s;
                            end
                        end
                        // Overflowing CALL still jumps; only the return address is lost.
                        OP_CALL: begin
                            pc_next_s = target_s;
                            if (depth_r == DEPTH_FULL) begin
                                err_set_s = 1'b1;
                            end else begin
                                push_s = 1'b1;
                            end
                        end
                        OP_RET: begin
                            if (depth_r == {DW{1'b0}}) begin
                                err_set_s = 1'b1;
                                pc_next_s = pc_plus1_s;
                            end else begin
                                pop_s     = 1'b1;
                                pc_next_s = stack_r[depth_dec_s[AW-1:0]];
                            end
                        end
                        OP_NOP: begin
`ifdef PC_SEQ_TIMED_NOP_EN
                            if (iInstruction[23:0] != 24'd0) begin
                                cnt_next_s   = iInstruction[23:0];
                                state_next_s = ST_DELAY;
                            end else begin
                                pc_next_s = pc_plus1_s;
                            end
`else
                            pc_next_s = pc_plus1_s;
`endif
                        end
                        default: pc_next_s = pc_plus1_s;
                    endcase
                end
`ifdef PC_SEQ_TIMED_NOP_EN
                ST_DELAY: begin
                    cnt_next_s = cnt_r - 24'd1;
                    if (cnt_r == 24'd1) begin
                        pc_next_s    = pc_plus1_s;
                        state_next_s = ST_RUN;
                    end else begin
                        pc_next_s = pc_r;
                    end
                end
`endif
                default: state_next_s = ST_SETTLE;
            endcase
        end
    end

    // Output logic: an instruction is executed only in RUN and only when not stalled.
    always_comb begin
        instr_valid_s = 1'b0;
        if (!iStall && (state_r == ST_RUN)) begin
            instr_valid_s = 1'b1;
        end else begin
            instr_valid_s = 1'b0;
        end
    end

    // Return-address stack and sticky overflow/underflow flag.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            depth_r <= {DW{1'b0}};
            err_r   <= 1'b0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                stack_r[i] <= 16'd0;
            end
        end else begin
            if (push_s) begin
                stack_r[depth_r[AW-1:0]] <= pc_plus1_s;
                depth_r                  <= depth_r + DEPTH_ONE;
            end else if (pop_s) begin
                depth_r <= depth_dec_s;
            end
            if (err_set_s) begin
                err_r <= 1'b1;
            end
        end
    end

    assign oAddress    = pc_r;
    assign oInstrValid = instr_valid_s;
    assign oStackDepth = depth_r;
    assign oStackError = err_r;

endmodule
